conv_out_writer: RTL and testbench
==================================

# conv_out_writer

Consumer end of the convolution index stream. Accepts one kernel tap per handshake: loop indices i/j/k/m/n, padded input coordinates, and the pixel, weight and bias operands. Accumulates the multiply-accumulate over each CONV_DIM_KERNEL×CONV_DIM_KERNEL window, then rounds, shifts, saturates and optionally rectifies the result. Writes one int8 output per window into the output feature-map memory.

## Interface
- CONV_DIM_KERNEL, 5, kernel side length
- CONV_DIM_OUT, 32, output map side length
- CONV_OUT_CH, 32, output channel count
- CONV_DIM_IMG, 32, input map side length (padding bound)
- ACC_W, 32, accumulator width
- BIAS_SHIFT, 0, left shift applied to bias
- OUT_SHIFT, 9, right shift applied to accumulator (≥1)
- RELU, 1, clamp negative outputs to 0 when 1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  tap present
- in_ready  out  1  tap accepted when in_valid & in_ready
- in_i, in_j, in_k, in_m, in_n  in  8 each  loop indices (unsigned)
- in_row, in_col  in  8 signed  input coordinates after stride/padding
- in_pixel, in_weight, in_bias  in  8 signed  operands (bias sampled only on first tap)
- wr_en  out  1  output memory write strobe
- wr_addr  out  16  i·DIM_OUT² + j·DIM_OUT + k
- wr_data  out  8 signed  quantised result
- done  out  1  sticky; final output written
- err  out  1  sticky; tap sequence violation

## Operation
- States: IDLE, ACC, WRITE, DONE.
- IDLE: in_ready=1. An accepted tap with m=0 and n=0 loads acc = (bias<<<BIAS_SHIFT) + (1<<(OUT_SHIFT-1)) + prod, latches i/j/k, and moves to ACC.
- Any accepted tap with m≠0 or n≠0 while in IDLE sets err. The tap is dropped and the state stays IDLE.
- Product: prod = pixel·weight, 16-bit signed, sign-extended to ACC_W.
  - prod is forced to 0 when in_row<0, in_col<0, in_row≥CONV_DIM_IMG or in_col≥CONV_DIM_IMG (signed compare).
- ACC: in_ready=1. Each accepted tap adds prod to acc (wraps modulo 2^ACC_W; no overflow detection).
  - Taps are expected in n-fastest order.
  - A tap whose (m,n) is not the successor of the previous tap, or whose i/j/k differ from the latched values, sets err. The tap is still accumulated.
  - A tap with m=n=CONV_DIM_KERNEL-1 is accumulated, and the state moves to WRITE.
- WRITE: in_ready=0 for exactly one cycle.
  - wr_en=1, wr_addr from latched i/j/k.
  - wr_data = sat8(acc >>> OUT_SHIFT): clamp to [-128,127]; with RELU=1, clamp to [0,127].
  - Next state: DONE if latched i=CONV_OUT_CH-1, j=k=CONV_DIM_OUT-1; otherwise IDLE.
- DONE: in_ready=0, done=1. Held until reset.
- Reset (any state, including mid-window): state IDLE, acc 0, latched indices 0, wr_en 0, wr_addr 0, wr_data 0, done 0, err 0. A partial window is discarded.

## Timing
- in_ready is a registered function of state only; it does not depend on in_valid.
- Accumulate latency: prod enters acc on the clock edge that accepts the tap.
- Write latency: wr_en is high in the cycle immediately after the last-tap handshake, for exactly one cycle.
  - wr_addr and wr_data are stable during that cycle and registered; they hold their values afterwards.
- Throughput: CONV_DIM_KERNEL² taps plus one bubble per output. Default: 26 cycles per output at full in_valid.
- done rises in the cycle after the final wr_en.
- err rises in the cycle after the offending handshake.
- in_valid held low mid-window stalls without losing state.

## Structure
- Shared package (`parameters.v`): `BYTE, ACC width default, state encodings, sat8 macro or function.
- One natural sub-module, conv_requant: combinational shift, saturate and ReLU (ACC_W → 8).
- Address product uses constant multipliers (parameters), no runtime multiply.

## Test plan
- Single window, all pixels=1, weights=1, bias=0, OUT_SHIFT=1 → one wr_en, wr_data=13 ((25+1)>>1), wr_addr=0.
- Padded corner: j=k=0 with PADDING=2 (rows/cols −2..2) → only 9 taps contribute. Pixels=4, weights=4, bias=0, OUT_SHIFT=4 → acc=8+144, wr_data=9.
- Saturation/ReLU: weights=127, pixels=127, OUT_SHIFT=1 → wr_data=127. Weights=−127 with RELU=1 → wr_data=0; with RELU=0 → −128.
- Out-of-order tap: first tap with n=1 → err=1, no write, state stays IDLE. Subsequent correct window still writes normally.
- Reset asserted after 10 taps, then a full clean window → only one write, from the clean window, with correct value; done=0, err=0.
- Full sweep with small params (KERNEL=2, DIM_OUT=2, OUT_CH=2), random operands → 8 writes at addresses 0..7 matching a reference model. done=1 after the 8th write; in_ready=0 thereafter.

Source files
------------

// File: rtl/conv_out_writer_pkg.sv
// ============================================================================
//  Module   : conv_out_writer_pkg
//  Purpose  : Shared widths, FSM encodings, index struct and int8 saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_out_writer_pkg;

    localparam int c_byte_w        = 8;
    localparam int c_acc_w_default = 32;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_acc   = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    typedef struct packed {
        logic [c_byte_w-1:0] i;
        logic [c_byte_w-1:0] j;
        logic [c_byte_w-1:0] k;
    } win_idx_t;

    // Clamp to int8; with relu the lower bound becomes 0.
    function automatic logic signed [c_byte_w-1:0] sat8(input logic signed [63:0] v,
                                                        input logic relu);
        if (v > 64'sd127)
            return 8'sd127;
        else if (relu && (v < 64'sd0))
            return 8'sd0;
        else if (v < -64'sd128)
            return -8'sd128;
        else
            return v[c_byte_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_out_writer_if.sv
// ============================================================================
//  Module   : conv_out_writer_if
//  Purpose  : Tap handshake and output-memory write bus of the writer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv_out_writer_if;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_i;
    logic [7:0]        in_j;
    logic [7:0]        in_k;
    logic [7:0]        in_m;
    logic [7:0]        in_n;
    logic signed [7:0] in_row;
    logic signed [7:0] in_col;
    logic signed [7:0] in_pixel;
    logic signed [7:0] in_weight;
    logic signed [7:0] in_bias;
    logic              wr_en;
    logic [15:0]       wr_addr;
    logic signed [7:0] wr_data;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_i, in_j, in_k, in_m, in_n,
        output in_row, in_col, in_pixel, in_weight, in_bias,
        input  in_ready, wr_en, wr_addr, wr_data, done, err
    );

    modport slave (
        input  in_valid, in_i, in_j, in_k, in_m, in_n,
        input  in_row, in_col, in_pixel, in_weight, in_bias,
        output in_ready, wr_en, wr_addr, wr_data, done, err
    );

endinterface

`default_nettype wire

// File: rtl/conv_out_writer_requant.sv
// ============================================================================
//  Module   : conv_out_writer_requant
//  Purpose  : Combinational arithmetic right shift, int8 saturation and ReLU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_out_writer_requant
    import conv_out_writer_pkg::*;
#(
    parameter int ACC_W     = c_acc_w_default,
    parameter int OUT_SHIFT = 9,
    parameter int RELU      = 1
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [c_byte_w-1:0] q
);

    logic signed [ACC_W-1:0] w_sh;

    assign w_sh = acc >>> OUT_SHIFT;
    assign q    = sat8(64'(w_sh), RELU != 0);

endmodule

`default_nettype wire

// File: rtl/conv_out_writer.sv
// ============================================================================
//  Module   : conv_out_writer
//  Purpose  : Accumulates one kernel window of taps and writes a requantised
//             int8 result per window into the output feature-map memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_out_writer
    import conv_out_writer_pkg::*;
#(
    parameter int CONV_DIM_KERNEL = 5,
    parameter int CONV_DIM_OUT    = 32,
    parameter int CONV_OUT_CH     = 32,
    parameter int CONV_DIM_IMG    = 32,
    parameter int ACC_W           = c_acc_w_default,
    parameter int BIAS_SHIFT      = 0,
    parameter int OUT_SHIFT       = 9,
    parameter int RELU            = 1
) (
    input  logic              clk,
    input  logic              reset,
    conv_out_writer_if.slave  bus
);

    localparam logic [7:0]              c_kmax   = 8'(CONV_DIM_KERNEL - 1);
    localparam logic [15:0]             c_dim    = 16'(CONV_DIM_OUT);
    localparam logic [15:0]             c_dim_sq = 16'(CONV_DIM_OUT * CONV_DIM_OUT);
    localparam logic signed [15:0]      c_img    = 16'(CONV_DIM_IMG);
    localparam logic signed [ACC_W-1:0] c_round  = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam win_idx_t c_last_idx = '{i: 8'(CONV_OUT_CH - 1),
                                        j: 8'(CONV_DIM_OUT - 1),
                                        k: 8'(CONV_DIM_OUT - 1)};

    logic [1:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    win_idx_t                r_idx;
    logic [7:0]              r_m;
    logic [7:0]              r_n;
    logic [15:0]             r_wr_addr;
    logic signed [7:0]       r_wr_data;
    logic                    r_err;

    logic                    w_idle;
    logic                    w_accept;
    win_idx_t                w_tap_idx;
    win_idx_t                w_idx;
    logic                    w_pad;
    logic signed [15:0]      w_prod16;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_bias_sh;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [15:0]             w_addr;
    logic signed [7:0]       w_q;
    logic                    w_first;
    logic                    w_last;
    logic [7:0]              w_succ_m;
    logic [7:0]              w_succ_n;
    logic                    w_seq_err;

    assign w_idle    = (r_state == c_st_idle);
    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_tap_idx = '{i: bus.in_i, j: bus.in_j, k: bus.in_k};
    assign w_idx     = w_idle ? w_tap_idx : r_idx;

    assign w_pad = bus.in_row[7] || bus.in_col[7] ||
                   (16'(bus.in_row) >= c_img) || (16'(bus.in_col) >= c_img);
    assign w_prod16   = 16'(bus.in_pixel) * 16'(bus.in_weight);
    assign w_prod     = w_pad ? '0 : ACC_W'(w_prod16);
    assign w_bias_sh  = ACC_W'(bus.in_bias) <<< BIAS_SHIFT;
    // The first tap of a window seeds the accumulator with bias and rounding.
    assign w_acc_next = (w_idle ? (w_bias_sh + c_round) : r_acc) + w_prod;
    assign w_addr     = 16'(w_idx.i) * c_dim_sq + 16'(w_idx.j) * c_dim + 16'(w_idx.k);

    assign w_first   = (bus.in_m == 8'd0) && (bus.in_n == 8'd0);
    assign w_last    = (bus.in_m == c_kmax) && (bus.in_n == c_kmax);
    assign w_succ_m  = (r_n == c_kmax) ? r_m + 8'd1 : r_m;
    assign w_succ_n  = (r_n == c_kmax) ? 8'd0 : r_n + 8'd1;
    assign w_seq_err = (bus.in_m != w_succ_m) || (bus.in_n != w_succ_n) ||
                       (w_tap_idx != r_idx);

    conv_out_writer_requant #(
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT),
        .RELU      (RELU)
    ) u_requant (
        .acc (w_acc_next),
        .q   (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_acc     <= '0;
            r_idx     <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_acc <= w_acc_next;
                            r_idx <= w_tap_idx;
                            r_m   <= 8'd0;
                            r_n   <= 8'd0;
                            if (w_last) begin
                                r_wr_addr <= w_addr;
                                r_wr_data <= w_q;
                                r_state   <= c_st_write;
                            end else begin
                                r_state <= c_st_acc;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_acc: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_m   <= bus.in_m;
                        r_n   <= bus.in_n;
                        if (w_seq_err)
                            r_err <= 1'b1;
                        if (w_last) begin
                            r_wr_addr <= w_addr;
                            r_wr_data <= w_q;
                            r_state   <= c_st_write;
                        end
                    end
                end
                c_st_write: r_state <= (r_idx == c_last_idx) ? c_st_done : c_st_idle;
                c_st_done:  r_state <= c_st_done;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.in_ready = w_idle || (r_state == c_st_acc);
    assign bus.wr_en    = (r_state == c_st_write);
    assign bus.done     = (r_state == c_st_done);
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_out_writer.sv
// ============================================================================
//  Module   : tb_conv_out_writer
//  Purpose  : Directed bench over four writer configurations sharing one
//             tap driver; instance 'sel' receives the handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_out_writer;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              t_valid;
    logic [7:0]        t_i, t_j, t_k, t_m, t_n;
    logic signed [7:0] t_row, t_col, t_pix, t_wt, t_bias;
    int                sel;

    logic              rdy   [4];
    logic              wen   [4];
    logic              dn    [4];
    logic              er    [4];
    logic [15:0]       waddr [4];
    logic signed [7:0] wdata [4];

    // 0: shift 1 relu   1: shift 4 relu   2: shift 1 no relu   3: small sweep
    for (genvar g = 0; g < 4; g++) begin : g_dut
        conv_out_writer_if u_if ();

        assign u_if.in_valid  = t_valid && (sel == g);
        assign u_if.in_i      = t_i;
        assign u_if.in_j      = t_j;
        assign u_if.in_k      = t_k;
        assign u_if.in_m      = t_m;
        assign u_if.in_n      = t_n;
        assign u_if.in_row    = t_row;
        assign u_if.in_col    = t_col;
        assign u_if.in_pixel  = t_pix;
        assign u_if.in_weight = t_wt;
        assign u_if.in_bias   = t_bias;
        assign rdy[g]   = u_if.in_ready;
        assign wen[g]   = u_if.wr_en;
        assign dn[g]    = u_if.done;
        assign er[g]    = u_if.err;
        assign waddr[g] = u_if.wr_addr;
        assign wdata[g] = u_if.wr_data;

        conv_out_writer #(
            .CONV_DIM_KERNEL ((g == 3) ? 2 : 5),
            .CONV_DIM_OUT    ((g == 3) ? 2 : 32),
            .CONV_OUT_CH     ((g == 3) ? 2 : 32),
            .CONV_DIM_IMG    (32),
            .ACC_W           (32),
            .BIAS_SHIFT      (0),
            .OUT_SHIFT       ((g == 1 || g == 3) ? 4 : 1),
            .RELU            ((g == 2 || g == 3) ? 0 : 1)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (u_if)
        );
    end

    int                wr_cnt [4] = '{default: 0};
    int                d_cnt = 0;
    logic [15:0]       d_addr [8];
    logic signed [7:0] d_data [8];

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (wen[g] === 1'b1) begin
                wr_cnt[g] <= wr_cnt[g] + 1;
                if (g == 3 && d_cnt < 8) begin
                    d_addr[d_cnt] <= waddr[3];
                    d_data[d_cnt] <= wdata[3];
                    d_cnt         <= d_cnt + 1;
                end
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        t_valid = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
    endtask

    task automatic send_tap(input int i, input int j, input int k, input int m, input int n,
                            input int row, input int col, input int pix, input int wt,
                            input int bias);
        int w;
        t_i = 8'(i); t_j = 8'(j); t_k = 8'(k); t_m = 8'(m); t_n = 8'(n);
        t_row = 8'(row); t_col = 8'(col); t_pix = 8'(pix); t_wt = 8'(wt); t_bias = 8'(bias);
        t_valid = 1'b1;
        w = 0;
        while (rdy[sel] !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) begin
            check("tap_wait_ready", 0, 1);
        end else begin
            @(posedge clk); #1;
        end
        t_valid = 1'b0;
    endtask

    task automatic send_window(input int i, input int j, input int k, input int row0,
                               input int col0, input int pix, input int wt, input int bias);
        int kk;
        kk = (sel == 3) ? 2 : 5;
        for (int m = 0; m < kk; m++)
            for (int n = 0; n < kk; n++)
                send_tap(i, j, k, m, n, row0 + m, col0 + n, pix, wt, bias);
    endtask

    // Called at #1 after the last-tap edge: the write cycle is in progress.
    task automatic expect_write(input string tag, input int addr, input int data);
        check({tag, "_wen"},  32'(wen[sel]), 1);
        check({tag, "_addr"}, 32'(waddr[sel]), addr);
        check({tag, "_data"}, 32'(wdata[sel]), data);
        check({tag, "_rdy"},  32'(rdy[sel]), 0);
        @(posedge clk); #1;
        check({tag, "_wen_off"}, 32'(wen[sel]), 0);
        check({tag, "_hold"},    32'(wdata[sel]), data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, c0, acc, q, idx;
        int e_data [8];

        reset = 1'b1; t_valid = 1'b0; sel = 0;
        t_i = '0; t_j = '0; t_k = '0; t_m = '0; t_n = '0;
        t_row = '0; t_col = '0; t_pix = '0; t_wt = '0; t_bias = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        check("rst_ready", 32'(rdy[0]), 1);
        check("rst_wen",   32'(wen[0]), 0);
        check("rst_addr",  32'(waddr[0]), 0);
        check("rst_data",  32'(wdata[0]), 0);
        check("rst_done",  32'(dn[0]), 0);
        check("rst_err",   32'(er[0]), 0);

        // Ones window: (25 + 1) >> 1 = 13, and 25 accept edges to the write.
        sel  = 0;
        base = wr_cnt[0];
        c0   = cyc;
        send_window(0, 0, 0, 0, 0, 1, 1, 0);
        check("ones_latency", cyc - c0, 25);
        expect_write("ones", 0, 13);
        check("ones_ready_back", 32'(rdy[0]), 1);
        check("ones_count", wr_cnt[0] - base, 1);

        // Bias and address: (-5 + 1 + 25*6) >> 1 = 73; 1*1024 + 2*32 + 3 = 1091.
        send_window(1, 2, 3, 0, 0, 2, 3, -5);
        expect_write("bias_addr", 1091, 73);

        send_window(0, 0, 2, 0, 0, 127, 127, 0);
        expect_write("sat_pos", 2, 127);
        send_window(0, 0, 3, 0, 0, 127, -127, 0);
        expect_write("relu_neg", 3, 0);
        sel = 2;
        send_window(0, 0, 4, 0, 0, 127, -127, 0);
        expect_write("sat_neg", 4, -128);

        // Padded corner: 9 in-bounds taps of 16, plus rounding 8 -> 152 >> 4 = 9.
        sel = 1;
        send_window(0, 0, 0, -2, -2, 4, 4, 0);
        expect_write("padded", 0, 9);

        // First tap out of order: flagged, dropped, IDLE kept.
        do_reset();
        sel  = 0;
        base = wr_cnt[0];
        send_tap(0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        check("ooo_err", 32'(er[0]), 1);
        check("ooo_ready", 32'(rdy[0]), 1);
        send_window(0, 0, 0, 0, 0, 1, 1, 0);
        expect_write("ooo_next", 0, 13);
        check("ooo_count", wr_cnt[0] - base, 1);
        check("ooo_err_sticky", 32'(er[0]), 1);

        // Skipped tap inside a window.
        do_reset();
        send_tap(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("seq_ok_err", 32'(er[0]), 0);
        send_tap(0, 0, 0, 0, 2, 0, 2, 1, 1, 0);
        check("seq_skip_err", 32'(er[0]), 1);

        // Reset after 10 taps discards the partial window.
        do_reset();
        base = wr_cnt[0];
        for (int t = 0; t < 10; t++)
            send_tap(0, 0, 0, t / 5, t % 5, t / 5, t % 5, 5, 5, 0);
        do_reset();
        check("mid_rst_err", 32'(er[0]), 0);
        send_window(0, 0, 1, 0, 0, 1, 1, 0);
        expect_write("mid_rst", 1, 13);
        check("mid_rst_count", wr_cnt[0] - base, 1);
        check("mid_rst_done", 32'(dn[0]), 0);
        check("mid_rst_err_end", 32'(er[0]), 0);

        // Full sweep of the small configuration against an integer model.
        do_reset();
        sel = 3;
        idx = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    int bias;
                    bias = int'($urandom_range(0, 255)) - 128;
                    acc  = bias + 8;
                    for (int m = 0; m < 2; m++)
                        for (int n = 0; n < 2; n++) begin
                            int p, w;
                            p = int'($urandom_range(0, 255)) - 128;
                            w = int'($urandom_range(0, 255)) - 128;
                            acc += p * w;
                            send_tap(i, j, k, m, n, m, n, p, w, bias);
                        end
                    q = acc >>> 4;
                    if (q > 127) q = 127;
                    if (q < -128) q = -128;
                    e_data[idx] = q;
                    idx++;
                end
        check("sweep_done_in_write", 32'(dn[3]), 0);
        @(posedge clk); #1;
        check("sweep_done", 32'(dn[3]), 1);
        check("sweep_ready", 32'(rdy[3]), 0);
        @(posedge clk); #1;
        check("sweep_count", d_cnt, 8);
        for (int e = 0; e < 8; e++) begin
            check($sformatf("sweep_addr%0d", e), 32'(d_addr[e]), e);
            check($sformatf("sweep_data%0d", e), 32'(d_data[e]), e_data[e]);
        end
        check("sweep_err", 32'(er[3]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
